// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter that shares one bank of clock-enabled registers between requesters.
// Issues at most one registered write (one-hot reg_ce, reg_d) plus a grant pulse per cycle.
module regbank_wr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned N    = 8,
  parameter int unsigned AW   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*AW-1:0]        addr,
  input  logic [NREQ*N-1:0]         wdata,
  input  logic                      hold,
  output logic [NREQ-1:0]           gnt,
  output logic [(2**AW)-1:0]        reg_ce,
  output logic [N-1:0]              reg_d,
  output logic                      busy
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [DEPTH-1:0] ce_q, ce_d;
  logic [N-1:0]    d_q, d_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] eff;
  logic            found;
  logic [PW-1:0]   win;
  logic            do_grant;
  logic [AW-1:0]   win_addr;
  logic [N-1:0]    win_data;
  int unsigned     idx;

  // Last cycle's winner is masked so it may drop req on the edge after its grant.
  assign eff = req & ~mask_q;

  // First set bit of eff searching upward from ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && eff[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign do_grant = found & ~hold;
  assign win_addr = addr[int'(win)*AW +: AW];
  assign win_data = wdata[int'(win)*N +: N];

  always_comb begin
    gnt_d   = '0;
    ce_d    = '0;
    d_d     = '0;
    ptr_d   = ptr_q;
    state_d = IDLE;
    if (do_grant) begin
      gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
      ce_d    = {{(DEPTH-1){1'b0}}, 1'b1} << win_addr;
      d_d     = win_data;
      ptr_d   = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
      state_d = GRANT;
    end
    // Mask only ever covers the previous cycle's grant.
    mask_d = gnt_d;
    busy_d = (eff != '0) | (state_q == GRANT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mask_q  <= '0;
      gnt_q   <= '0;
      ce_q    <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      ce_q    <= ce_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign reg_ce = ce_q;
  assign reg_d  = d_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed, table-driven bench for regbank_wr_arbiter (NREQ=4, N=8, AW=2).
module tb_regbank_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        hold;
  logic [3:0]  gnt;
  logic [3:0]  reg_ce;
  logic [7:0]  reg_d;
  logic        busy;

  regbank_wr_arbiter #(.NREQ(4), .N(8), .AW(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .addr   (addr),
    .wdata  (wdata),
    .hold   (hold),
    .gnt    (gnt),
    .reg_ce (reg_ce),
    .reg_d  (reg_d),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        hold;
    logic [3:0]  gnt;
    logic [3:0]  ce;
    logic [7:0]  d;
    logic        busy;
  } vec_t;

  vec_t vt[21];
  int n_cmp;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] ec,
                         input logic [7:0] ed, input logic eb);
    chk({tag, " gnt"}, 32'(gnt), 32'(eg));
    chk({tag, " reg_ce"}, 32'(reg_ce), 32'(ec));
    chk({tag, " reg_d"}, 32'(reg_d), 32'(ed));
    chk({tag, " busy"}, 32'(busy), 32'(eb));
  endtask

  localparam logic [7:0]  A1 = 8'h08;        // slice1 = 2
  localparam logic [31:0] W1 = 32'h0000A500;
  localparam logic [7:0]  AD = 8'hE4;        // slice i = i
  localparam logic [31:0] WD = 32'h43322110;
  localparam logic [7:0]  AC = 8'h00;        // all target register 0
  localparam logic [31:0] WC = 32'h33001100;

  initial begin
    n_cmp = 0;
    n_err = 0;
    // single request
    vt[0]  = '{4'b0010, A1, W1, 1'b0, 4'b0010, 4'b0100, 8'hA5, 1'b1};
    vt[1]  = '{4'b0010, A1, W1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1};
    vt[2]  = '{4'b0000, A1, W1, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0};
    // hold with everyone requesting, ptr=2
    vt[3]  = '{4'b1111, AD, WD, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1};
    vt[4]  = '{4'b1111, AD, WD, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1};
    // release: rotation 2,3,0,1,2
    vt[5]  = '{4'b1111, AD, WD, 1'b0, 4'b0100, 4'b0100, 8'h32, 1'b1};
    vt[6]  = '{4'b1111, AD, WD, 1'b0, 4'b1000, 4'b1000, 8'h43, 1'b1};
    vt[7]  = '{4'b1111, AD, WD, 1'b0, 4'b0001, 4'b0001, 8'h10, 1'b1};
    vt[8]  = '{4'b1111, AD, WD, 1'b0, 4'b0010, 4'b0010, 8'h21, 1'b1};
    vt[9]  = '{4'b1111, AD, WD, 1'b0, 4'b0100, 4'b0100, 8'h32, 1'b1};
    // requester 2 still high on the edge after its grant: masked
    vt[10] = '{4'b1111, AD, WD, 1'b0, 4'b1000, 4'b1000, 8'h43, 1'b1};
    vt[11] = '{4'b1011, AD, WD, 1'b0, 4'b0001, 4'b0001, 8'h10, 1'b1};
    vt[12] = '{4'b1011, AD, WD, 1'b0, 4'b0010, 4'b0010, 8'h21, 1'b1};
    vt[13] = '{4'b1011, AD, WD, 1'b0, 4'b1000, 4'b1000, 8'h43, 1'b1};
    // sole requester 3: one masked cycle then regranted
    vt[14] = '{4'b1000, AD, WD, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1};
    vt[15] = '{4'b1000, AD, WD, 1'b0, 4'b1000, 4'b1000, 8'h43, 1'b1};
    vt[16] = '{4'b0000, AD, WD, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1};
    vt[17] = '{4'b0000, AD, WD, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0};
    // address conflict on register 0, ptr=0
    vt[18] = '{4'b1010, AC, WC, 1'b0, 4'b0010, 4'b0001, 8'h11, 1'b1};
    vt[19] = '{4'b1010, AC, WC, 1'b0, 4'b1000, 4'b0001, 8'h33, 1'b1};
    vt[20] = '{4'b0000, AC, WC, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1};

    rst   = 1'b1;
    req   = '0;
    addr  = '0;
    wdata = '0;
    hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 4'b0000, 8'h00, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      req   = vt[i].req;
      addr  = vt[i].addr;
      wdata = vt[i].wdata;
      hold  = vt[i].hold;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vt[i].gnt, vt[i].ce, vt[i].d, vt[i].busy);
    end

    // Reset asserted mid-grant clears outputs before the next edge.
    req   = 4'b1111;
    addr  = AD;
    wdata = WD;
    @(posedge clk);
    #1;
    chk_all("pre_rst0", 4'b0001, 4'b0001, 8'h10, 1'b1);
    @(posedge clk);
    #1;
    chk_all("pre_rst1", 4'b0010, 4'b0010, 8'h21, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 4'b0000, 8'h00, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst", 4'b0001, 4'b0001, 8'h10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
